turfiolos_top: RTL and testbench

- Local-bus slave with a serial line-of-sight (LOS) transmitter, clocked by the bus clock BCLKO (33 MHz, 30 ns period).
- Host writes up to BUF_WORDS 32-bit words into a transmit buffer (nCS3 space), sets a length and a GO bit (nCS2 space).
- Block shifts the words out MSB-first on SDAT/SCLK, plus a Manchester (biphase) copy on BIPHASE.

---
 rtl/turfiolos_pkg.sv | 35 +++
 rtl/turfiolos_los_tx.sv | 145 ++++++++++++++
 rtl/turfiolos_top.sv | 156 +++++++++++++++
 tb/tb_turfiolos_top.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turfiolos_pkg.sv
// turfiolos_pkg
//   Shared definitions for the local-bus LOS transmitter block.
//   - Register word indices in the nCS2 space.
//   - CTRL/STAT bit positions.
//   - Bus FSM and transmitter state types.
//   - statusWord(): packs BUSY/DONE into the CTRL/STAT read value.
package turfiolos_pkg;

  localparam logic [10:0] REG_CTRL    = 11'd0;
  localparam logic [10:0] REG_LENGTH  = 11'd1;
  localparam logic [10:0] REG_VERSION = 11'd2;

  localparam int CTRL_GO   = 0;  // write: start transmission
  localparam int STAT_BUSY = 1;  // read: transmitter active
  localparam int CTRL_DONE = 2;  // read: sticky DONE, write 1: clear DONE

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_DATA = 1'b1
  } busState_t;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } txState_t;

  function automatic logic [31:0] statusWord(input logic busy, input logic done);
    logic [31:0] w;
    w            = '0;
    w[STAT_BUSY] = busy;
    w[CTRL_DONE] = done;
    return w;
  endfunction

endpackage

// File: rtl/turfiolos_los_tx.sv
// turfiolos_los_tx
//   Serializer for the line-of-sight link. Sends `length` 32-bit words,
//   MSB first, each bit taking HALF_BIT cycles with SCLK low followed by
//   HALF_BIT cycles with SCLK high. BIPHASE carries a Manchester copy of SDAT
//   (inverted in the low half, true in the high half).
// Ports:
//   clk, nRst        clock, asynchronous active-low reset
//   go               one-cycle start request (ignored while busy or length==0)
//   length           number of words to send
//   doneClr          clears the sticky done flag
//   fetchAddr        buffer word index to read; fetchData is its async contents
//   busy, done       status
//   sdat, sclk, biphase  serial outputs (all registered)
module turfiolos_los_tx
  import turfiolos_pkg::*;
#(
  parameter int BUF_WORDS = 256,
  parameter int HALF_BIT  = 2,
  localparam int AW = $clog2(BUF_WORDS),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          go,
  input  logic [LW-1:0] length,
  input  logic          doneClr,
  output logic [AW-1:0] fetchAddr,
  input  logic [31:0]   fetchData,
  output logic          busy,
  output logic          done,
  output logic          sdat,
  output logic          sclk,
  output logic          biphase
);

  localparam int CW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_BIT - 1);

  txState_t      stateReg,   stateNext;
  logic          doneReg,    doneNext;
  logic [31:0]   shiftReg,   shiftNext;
  logic          sclkReg,    sclkNext;
  logic          biphaseReg, biphaseNext;
  logic [CW-1:0] cntReg,     cntNext;
  logic [4:0]    bitReg,     bitNext;
  logic [AW-1:0] wordReg,    wordNext;   // index of the next word to fetch
  logic [LW-1:0] leftReg,    leftNext;   // words still to fetch after current

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      stateReg   <= TX_IDLE;
      doneReg    <= 1'b0;
      shiftReg   <= '0;
      sclkReg    <= 1'b0;
      biphaseReg <= 1'b0;
      cntReg     <= '0;
      bitReg     <= '0;
      wordReg    <= '0;
      leftReg    <= '0;
    end else begin
      stateReg   <= stateNext;
      doneReg    <= doneNext;
      shiftReg   <= shiftNext;
      sclkReg    <= sclkNext;
      biphaseReg <= biphaseNext;
      cntReg     <= cntNext;
      bitReg     <= bitNext;
      wordReg    <= wordNext;
      leftReg    <= leftNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    doneNext    = doneReg;
    shiftNext   = shiftReg;
    sclkNext    = sclkReg;
    biphaseNext = biphaseReg;
    cntNext     = cntReg;
    bitNext     = bitReg;
    wordNext    = wordReg;
    leftNext    = leftReg;

    if (doneClr) doneNext = 1'b0;

    unique case (stateReg)
      TX_IDLE: begin
        if (go && (length != '0)) begin
          // Word 0 is loaded on the GO edge so its MSB is on SDAT next cycle.
          stateNext   = TX_SHIFT;
          doneNext    = 1'b0;
          shiftNext   = fetchData;
          sclkNext    = 1'b0;
          biphaseNext = ~fetchData[31];
          cntNext     = '0;
          bitNext     = 5'd31;
          wordNext    = wordReg + 1'b1;
          leftNext    = length - 1'b1;
        end
      end
      TX_SHIFT: begin
        if (cntReg != CNT_LAST) begin
          cntNext = cntReg + 1'b1;
        end else begin
          cntNext = '0;
          if (!sclkReg) begin
            // Low half finished: rising SCLK, BIPHASE follows true data.
            sclkNext    = 1'b1;
            biphaseNext = shiftReg[31];
          end else if (bitReg != 5'd0) begin
            shiftNext   = {shiftReg[30:0], 1'b0};
            bitNext     = bitReg - 5'd1;
            sclkNext    = 1'b0;
            biphaseNext = ~shiftReg[30];
          end else if (leftReg != '0) begin
            // Next word is read from the buffer only now, so late host
            // writes to it are still picked up.
            shiftNext   = fetchData;
            wordNext    = wordReg + 1'b1;
            leftNext    = leftReg - 1'b1;
            bitNext     = 5'd31;
            sclkNext    = 1'b0;
            biphaseNext = ~fetchData[31];
          end else begin
            stateNext   = TX_IDLE;
            doneNext    = 1'b1;
            shiftNext   = '0;
            sclkNext    = 1'b0;
            biphaseNext = 1'b0;
            wordNext    = '0;
          end
        end
      end
      default: stateNext = TX_IDLE;
    endcase
  end

  assign fetchAddr = wordReg;
  assign busy      = (stateReg == TX_SHIFT);
  assign done      = doneReg;
  assign sdat      = shiftReg[31];
  assign sclk      = sclkReg;
  assign biphase   = biphaseReg;

endmodule

// File: rtl/turfiolos_top.sv
// turfiolos_top
//   Local-bus slave with a transmit buffer and a serial LOS transmitter.
//   nCS2 space: CTRL/STAT (0), LENGTH (1), VERSION (2); other indices read 0.
//   nCS3 space: BUF_WORDS x 32 transmit buffer, upper address bits alias.
// Ports:
//   BCLKO, nRST              bus clock, asynchronous active-low reset
//   nADS, WnR, nBLAST        address strobe, direction, last-beat
//   nCS2, nCS3, LA           chip selects and word address (sampled with nADS)
//   LD                       bidirectional data, driven only in read data phase
//   nREADY, nBTERM           beat acknowledge, burst terminate (always high)
//   SDAT, SCLK, BIPHASE      serial link outputs
module turfiolos_top
  import turfiolos_pkg::*;
#(
  parameter int          BUF_WORDS = 256,
  parameter int          HALF_BIT  = 2,
  parameter logic [31:0] VERSION   = 32'h544C0001
) (
  input  logic        BCLKO,
  input  logic        nRST,
  input  logic        nADS,
  input  logic        WnR,
  input  logic        nBLAST,
  input  logic        nCS2,
  input  logic        nCS3,
  input  logic [12:2] LA,
  inout  wire  [31:0] LD,
  output logic        nREADY,
  output logic        nBTERM,
  output logic        SDAT,
  output logic        SCLK,
  output logic        BIPHASE
);

  localparam int AW = $clog2(BUF_WORDS);
  localparam int LW = AW + 1;

  busState_t     stateReg,    stateNext;
  logic [10:0]   addrReg,     addrNext;
  logic          wnrReg,      wnrNext;
  logic          bufSpaceReg, bufSpaceNext;
  logic          nReadyReg,   nReadyNext;
  logic [LW-1:0] lengthReg,   lengthNext;

  logic          beat;
  logic          regWrite;
  logic          bufWrite;
  logic          goPulse;
  logic          doneClr;
  logic [31:0]   rdData;
  logic [AW-1:0] fetchAddr;
  logic [31:0]   fetchData;
  logic          txBusy;
  logic          txDone;

  logic [31:0]   mem [BUF_WORDS];

  always_ff @(posedge BCLKO or negedge nRST) begin
    if (!nRST) begin
      stateReg    <= BUS_IDLE;
      addrReg     <= '0;
      wnrReg      <= 1'b0;
      bufSpaceReg <= 1'b0;
      nReadyReg   <= 1'b1;
      lengthReg   <= '0;
    end else begin
      stateReg    <= stateNext;
      addrReg     <= addrNext;
      wnrReg      <= wnrNext;
      bufSpaceReg <= bufSpaceNext;
      nReadyReg   <= nReadyNext;
      lengthReg   <= lengthNext;
    end
  end

  // nREADY is low for every DATA cycle, so every edge in DATA is a beat.
  assign beat     = (stateReg == BUS_DATA);
  assign regWrite = beat && wnrReg && !bufSpaceReg;
  assign bufWrite = beat && wnrReg && bufSpaceReg;
  assign goPulse  = regWrite && (addrReg == REG_CTRL) && LD[CTRL_GO];
  assign doneClr  = regWrite && (addrReg == REG_CTRL) && LD[CTRL_DONE];

  always_comb begin
    stateNext    = stateReg;
    addrNext     = addrReg;
    wnrNext      = wnrReg;
    bufSpaceNext = bufSpaceReg;
    nReadyNext   = nReadyReg;
    lengthNext   = lengthReg;

    if (regWrite && (addrReg == REG_LENGTH)) lengthNext = LD[LW-1:0];

    unique case (stateReg)
      BUS_IDLE: begin
        if (!nADS && (!nCS2 || !nCS3)) begin
          stateNext    = BUS_DATA;
          addrNext     = LA;
          wnrNext      = WnR;
          bufSpaceNext = nCS2;  // nCS2 low takes priority over nCS3
          nReadyNext   = 1'b0;
        end
      end
      BUS_DATA: begin
        addrNext = addrReg + 11'd1;
        if (!nBLAST) begin
          stateNext  = BUS_IDLE;
          nReadyNext = 1'b1;
        end
      end
      default: stateNext = BUS_IDLE;
    endcase
  end

  always_comb begin
    rdData = '0;
    if (bufSpaceReg) begin
      rdData = mem[addrReg[AW-1:0]];
    end else begin
      unique case (addrReg)
        REG_CTRL:    rdData = statusWord(txBusy, txDone);
        REG_LENGTH:  rdData = 32'(lengthReg);
        REG_VERSION: rdData = VERSION;
        default:     rdData = '0;
      endcase
    end
  end

  assign LD     = (beat && !wnrReg) ? rdData : 'z;
  assign nREADY = nReadyReg;
  assign nBTERM = 1'b1;

  always_ff @(posedge BCLKO) begin
    if (bufWrite) mem[addrReg[AW-1:0]] <= LD;
  end

  assign fetchData = mem[fetchAddr];

  turfiolos_los_tx #(
    .BUF_WORDS (BUF_WORDS),
    .HALF_BIT  (HALF_BIT)
  ) u_losTx (
    .clk       (BCLKO),
    .nRst      (nRST),
    .go        (goPulse),
    .length    (lengthReg),
    .doneClr   (doneClr),
    .fetchAddr (fetchAddr),
    .fetchData (fetchData),
    .busy      (txBusy),
    .done      (txDone),
    .sdat      (SDAT),
    .sclk      (SCLK),
    .biphase   (BIPHASE)
  );

endmodule

// File: tb/tb_turfiolos_top.sv
`timescale 1ns/1ps
module tb_turfiolos_top;

  localparam int          BUF_WORDS = 256;
  localparam int          HB        = 2;
  localparam logic [31:0] VER       = 32'h544C0001;
  localparam logic [31:0] PAT       = 32'h5AC33CA5;

  logic        BCLKO = 1'b0;
  logic        nRST  = 1'b0;
  logic        nADS  = 1'b1;
  logic        WnR   = 1'b0;
  logic        nBLAST = 1'b1;
  logic        nCS2  = 1'b1;
  logic        nCS3  = 1'b1;
  logic [12:2] LA    = '0;
  wire  [31:0] LD;
  logic        nREADY, nBTERM, SDAT, SCLK, BIPHASE;

  logic        tbDrv  = 1'b0;
  logic [31:0] tbData = '0;
  assign LD = tbDrv ? tbData : 'z;

  always #15 BCLKO = ~BCLKO;

  turfiolos_top #(
    .BUF_WORDS (BUF_WORDS),
    .HALF_BIT  (HB),
    .VERSION   (VER)
  ) dut (
    .BCLKO   (BCLKO),
    .nRST    (nRST),
    .nADS    (nADS),
    .WnR     (WnR),
    .nBLAST  (nBLAST),
    .nCS2    (nCS2),
    .nCS3    (nCS3),
    .LA      (LA),
    .LD      (LD),
    .nREADY  (nREADY),
    .nBTERM  (nBTERM),
    .SDAT    (SDAT),
    .SCLK    (SCLK),
    .BIPHASE (BIPHASE)
  );

  int checks = 0;
  int fails  = 0;

  // Cycle counter and per-cycle record of the serial outputs.
  int         cyc = 0;
  logic [2:0] trace [8192];
  always @(posedge BCLKO) cyc++;
  always @(negedge BCLKO) trace[cyc % 8192] = {SCLK, SDAT, BIPHASE};

  logic [31:0] wrBuf [4];
  logic [31:0] rdBuf [4];
  logic [31:0] expWords [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One bus transaction of n beats; counts nREADY-low cycles and checks that
  // LD is released on the cycle after the last beat.
  task automatic busCycle(input logic cs2n, input logic cs3n, input logic wr,
                          input logic [10:0] addr, input int n,
                          output int rdyCnt, output logic ldFree);
    @(negedge BCLKO);
    nADS = 1'b0; WnR = wr; nCS2 = cs2n; nCS3 = cs3n; LA = addr;
    @(negedge BCLKO);
    nADS = 1'b1; nCS2 = 1'b1; nCS3 = 1'b1;
    rdyCnt = 0;
    for (int i = 0; i < n; i++) begin
      nBLAST = (i == n - 1) ? 1'b0 : 1'b1;
      tbDrv  = wr;
      tbData = wrBuf[i];
      #1;
      if (nREADY == 1'b0) rdyCnt++;
      rdBuf[i] = LD;
      @(negedge BCLKO);
    end
    nBLAST = 1'b1;
    tbDrv  = 1'b1;
    tbData = PAT;
    #1;
    ldFree = (LD === PAT);
    tbDrv  = 1'b0;
    if (nREADY == 1'b0) rdyCnt++;
    repeat (2) begin
      @(negedge BCLKO);
      #1;
      if (nREADY == 1'b0) rdyCnt++;
    end
  endtask

  task automatic regWrite(input logic [10:0] addr, input logic [31:0] d);
    int r; logic f;
    wrBuf[0] = d;
    busCycle(1'b0, 1'b1, 1'b1, addr, 1, r, f);
  endtask

  task automatic regRead(input logic [10:0] addr, output logic [31:0] d);
    int r; logic f;
    busCycle(1'b0, 1'b1, 1'b0, addr, 1, r, f);
    d = rdBuf[0];
  endtask

  task automatic bufWrite(input logic [10:0] addr, input logic [31:0] d);
    int r; logic f;
    wrBuf[0] = d;
    busCycle(1'b1, 1'b0, 1'b1, addr, 1, r, f);
  endtask

  // Single-beat GO write; returns at the first cycle after the GO edge.
  task automatic sendGo(output int k);
    @(negedge BCLKO);
    nADS = 1'b0; WnR = 1'b1; nCS2 = 1'b0; nCS3 = 1'b1; LA = 11'd0;
    @(negedge BCLKO);
    nADS = 1'b1; nCS2 = 1'b1; nBLAST = 1'b0; tbDrv = 1'b1; tbData = 32'h1;
    @(negedge BCLKO);
    nBLAST = 1'b1; tbDrv = 1'b0;
    k = cyc;
  endtask

  // Reference: cycle j after GO lies in bit j/(2*HB); SCLK is high in the
  // second half; BIPHASE is SDAT in the high half and its inverse in the low
  // half; after the last bit everything reads 0.
  task automatic checkTrace(input string name, input int k, input int len);
    int total, bad, firstBad, b, half;
    logic [31:0] w;
    logic bitv;
    logic [2:0] exp;
    total = len * 32 * 2 * HB;
    bad = 0;
    firstBad = -1;
    while (cyc < k + total + 2) @(negedge BCLKO);
    for (int j = 0; j < total + 2; j++) begin
      if (j < total) begin
        b    = j / (2 * HB);
        half = (j / HB) % 2;
        w    = expWords[b / 32];
        bitv = w[31 - (b % 32)];
        exp  = {half[0], bitv, (half == 1) ? bitv : ~bitv};
      end else begin
        exp = 3'b000;
      end
      if (trace[(k + j) % 8192] !== exp) begin
        bad++;
        if (firstBad < 0) firstBad = j;
      end
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d cycles differ from the expected SCLK/SDAT/BIPHASE waveform (first at cycle %0d after GO), required 0",
               name, bad, firstBad + 1);
    end else begin
      $display("ok   %s: %0d words, %0d cycles", name, len, total);
    end
  endtask

  typedef struct {
    string       name;
    logic        cs2n;
    logic        cs3n;
    logic        wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic        chkRd;
    logic [31:0] expRd;
    int          expRdy;
  } vec_t;

  vec_t vecs [19];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rdy;
    logic        free;
    logic [31:0] d;
    int          k;
    int          len;

    // Reset state
    nRST = 1'b0;
    repeat (3) @(negedge BCLKO);
    check("reset outputs {nREADY,nBTERM,SCLK,SDAT,BIPHASE}",
          {27'b0, nREADY, nBTERM, SCLK, SDAT, BIPHASE}, 32'h18);
    tbDrv = 1'b1; tbData = PAT; #1;
    check("reset LD released", LD, PAT);
    tbDrv = 1'b0;
    nRST = 1'b1;
    repeat (2) @(negedge BCLKO);

    //           name                   cs2n cs3n wr  addr     wdata         chk  expRd         rdy
    vecs[0]  = '{"version read",        1'b0,1'b1,1'b0,11'd2,  32'h0,        1'b1,VER,          1};
    vecs[1]  = '{"length write 3",      1'b0,1'b1,1'b1,11'd1,  32'h3,        1'b0,32'h0,        1};
    vecs[2]  = '{"length read",         1'b0,1'b1,1'b0,11'd1,  32'h0,        1'b1,32'h3,        1};
    vecs[3]  = '{"unmapped read",       1'b0,1'b1,1'b0,11'd5,  32'h0,        1'b1,32'h0,        1};
    vecs[4]  = '{"unmapped write",      1'b0,1'b1,1'b1,11'd5,  32'hFFFFFFFF, 1'b0,32'h0,        1};
    vecs[5]  = '{"unmapped reread",     1'b0,1'b1,1'b0,11'd5,  32'h0,        1'b1,32'h0,        1};
    vecs[6]  = '{"no select ignored",   1'b1,1'b1,1'b1,11'd1,  32'h9,        1'b0,32'h0,        0};
    vecs[7]  = '{"length after nosel",  1'b0,1'b1,1'b0,11'd1,  32'h0,        1'b1,32'h3,        1};
    vecs[8]  = '{"version write",       1'b0,1'b1,1'b1,11'd2,  32'h0,        1'b0,32'h0,        1};
    vecs[9]  = '{"version read-only",   1'b0,1'b1,1'b0,11'd2,  32'h0,        1'b1,VER,          1};
    vecs[10] = '{"buf1 write",          1'b1,1'b0,1'b1,11'd1,  32'hDEADBEEF, 1'b0,32'h0,        1};
    vecs[11] = '{"both selects write",  1'b0,1'b0,1'b1,11'd1,  32'h5,        1'b0,32'h0,        1};
    vecs[12] = '{"both sel -> reg",     1'b0,1'b1,1'b0,11'd1,  32'h0,        1'b1,32'h5,        1};
    vecs[13] = '{"both sel buf intact", 1'b1,1'b0,1'b0,11'd1,  32'h0,        1'b1,32'hDEADBEEF, 1};
    vecs[14] = '{"buf alias write",     1'b1,1'b0,1'b1,11'h102,32'hCAFEF00D, 1'b0,32'h0,        1};
    vecs[15] = '{"buf alias read",      1'b1,1'b0,1'b0,11'd2,  32'h0,        1'b1,32'hCAFEF00D, 1};
    vecs[16] = '{"length write max",    1'b0,1'b1,1'b1,11'd1,  32'hFFFFFFFF, 1'b0,32'h0,        1};
    vecs[17] = '{"length width",        1'b0,1'b1,1'b0,11'd1,  32'h0,        1'b1,32'h1FF,      1};
    vecs[18] = '{"stat idle",           1'b0,1'b1,1'b0,11'd0,  32'h0,        1'b1,32'h0,        1};

    for (int i = 0; i < 19; i++) begin
      wrBuf[0] = vecs[i].wdata;
      busCycle(vecs[i].cs2n, vecs[i].cs3n, vecs[i].wr, vecs[i].addr, 1, rdy, free);
      check({vecs[i].name, " nREADY cycles"}, rdy, vecs[i].expRdy);
      if (vecs[i].chkRd) begin
        check({vecs[i].name, " data"}, rdBuf[0], vecs[i].expRd);
        check({vecs[i].name, " LD released"}, {31'b0, free}, 32'h1);
      end
    end

    // Burst write then burst read of four buffer words
    wrBuf = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    busCycle(1'b1, 1'b0, 1'b1, 11'd0, 4, rdy, free);
    check("burst write nREADY cycles", rdy, 4);
    busCycle(1'b1, 1'b0, 1'b0, 11'd0, 4, rdy, free);
    check("burst read nREADY cycles", rdy, 4);
    for (int i = 0; i < 4; i++) check($sformatf("burst read beat %0d", i), rdBuf[i], wrBuf[i]);

    // Single-word transfer with a known pattern
    bufWrite(11'd0, 32'hA5000001);
    regWrite(11'd1, 32'd1);
    expWords[0] = 32'hA5000001;
    sendGo(k);
    checkTrace("tx A5000001", k, 1);
    regRead(11'd0, d);
    check("stat after tx", d, 32'h4);

    // GO with LENGTH=0 is ignored (DONE stays), then clear DONE
    regWrite(11'd1, 32'd0);
    regWrite(11'd0, 32'h1);
    regRead(11'd0, d);
    check("go with length 0", d, 32'h4);
    regWrite(11'd0, 32'h4);
    regRead(11'd0, d);
    check("done clear", d, 32'h0);

    // STAT during transfer, and GO while busy must not restart
    expWords[0] = $urandom;
    bufWrite(11'd0, expWords[0]);
    regWrite(11'd1, 32'd1);
    regWrite(11'd0, 32'h4);
    sendGo(k);
    regRead(11'd0, d);
    check("stat while busy", d, 32'h2);
    regWrite(11'd0, 32'h1);
    checkTrace("tx with go while busy", k, 1);
    regRead(11'd0, d);
    check("stat after busy go", d, 32'h4);

    // Word 1 rewritten while word 0 is still going out
    expWords[0] = $urandom;
    bufWrite(11'd0, expWords[0]);
    bufWrite(11'd1, $urandom);
    regWrite(11'd1, 32'd2);
    sendGo(k);
    expWords[1] = $urandom;
    bufWrite(11'd1, expWords[1]);
    checkTrace("tx with late buffer write", k, 2);

    // Randomized transfers
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        wrBuf[i]    = $urandom;
        expWords[i] = wrBuf[i];
      end
      busCycle(1'b1, 1'b0, 1'b1, 11'd0, len, rdy, free);
      regWrite(11'd1, 32'(len));
      regRead(11'd1, d);
      check($sformatf("random %0d length", r), d, 32'(len));
      sendGo(k);
      checkTrace($sformatf("random tx %0d", r), k, len);
      regRead(11'd0, d);
      check($sformatf("random %0d stat", r), d, 32'h4);
    end

    // Reset in the middle of a word
    expWords[0] = 32'hFFFFFFFF;
    bufWrite(11'd0, expWords[0]);
    regWrite(11'd1, 32'd1);
    sendGo(k);
    repeat (22) @(negedge BCLKO);
    check("mid-word outputs before reset", {29'b0, SCLK, SDAT, BIPHASE}, 32'h7);
    nRST = 1'b0;
    #1;
    check("outputs on async reset", {27'b0, nREADY, nBTERM, SCLK, SDAT, BIPHASE}, 32'h18);
    @(negedge BCLKO);
    nRST = 1'b1;
    regRead(11'd0, d);
    check("stat after reset", d, 32'h0);
    regRead(11'd1, d);
    check("length after reset", d, 32'h0);
    expWords[0] = $urandom;
    bufWrite(11'd0, expWords[0]);
    regWrite(11'd1, 32'd1);
    sendGo(k);
    checkTrace("tx after reset", k, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
